// File: rtl/wb_host_pkg.sv
// Shared types and address-field constants for the Wishbone host master.
// Offset arithmetic lives here so the slave-select field is preserved in exactly one place.
package wb_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    BUS,
    RHOLD,
    DONE
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;

  localparam int SLAVE_SEL_MSB = 31;
  localparam int SLAVE_SEL_LSB = 24;
  localparam int OFFSET_W      = 24;

  // Advance the slave offset by one beat; the slave-select byte never carries in.
  function automatic logic [31:0] next_adr(input logic [31:0] adr);
    logic [OFFSET_W-1:0] ofs;
    ofs = adr[OFFSET_W-1:0] + OFFSET_W'(1);
    return {adr[SLAVE_SEL_MSB:SLAVE_SEL_LSB], ofs};
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts cycles a bus beat has been outstanding; expired is high during the TIMEOUT-th cycle.
// Synchronous clear takes priority, so the count restarts at 0 whenever a new beat is entered.
module wb_timeout_counter #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  // cnt holds completed cycles, so this fires while the last permitted cycle is in progress.
  assign expired = en && (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/wishbone_host_master.sv
// Host command to sequential single-beat Wishbone classic cycles; read accept -> stb next cycle.
// Write data is requested one beat at a time and read data is held until the host takes it.
module wishbone_host_master
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_stb_i,
  output logic        cmd_rdy_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [23:0] cmd_len_i,
  input  logic [31:0] wdat_i,
  input  logic        wdat_vld_i,
  output logic        wdat_rdy_o,
  output logic [31:0] rdat_o,
  output logic        rdat_vld_o,
  input  logic        rdat_rdy_i,
  output logic        done_o,
  output logic [1:0]  status_o,
  output logic        irq_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_int_i
);

  state_t      state;
  logic [23:0] remaining;
  logic        int_q;
  logic        in_bus;
  logic        to_expired;

  assign in_bus  = (state == BUS);
  assign m_sel_o = 4'hF;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!in_bus),
    .en      (in_bus),
    .expired (to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      cmd_rdy_o  <= 1'b1;
      wdat_rdy_o <= 1'b0;
      rdat_o     <= '0;
      rdat_vld_o <= 1'b0;
      done_o     <= 1'b0;
      status_o   <= ST_OK;
      m_we_o     <= 1'b0;
      m_cyc_o    <= 1'b0;
      m_stb_o    <= 1'b0;
      m_adr_o    <= '0;
      m_dat_o    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_stb_i) begin
            m_we_o    <= cmd_we_i;
            m_adr_o   <= cmd_adr_i;
            remaining <= (cmd_len_i == 24'd0) ? 24'd1 : cmd_len_i;
            status_o  <= ST_OK;
            cmd_rdy_o <= 1'b0;
            if (cmd_we_i) begin
              state      <= WDATA;
              wdat_rdy_o <= 1'b1;
            end else begin
              state   <= BUS;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
            end
          end
        end
        WDATA: begin
          if (wdat_vld_i) begin
            m_dat_o    <= wdat_i;
            wdat_rdy_o <= 1'b0;
            state      <= BUS;
            m_cyc_o    <= 1'b1;
            m_stb_o    <= 1'b1;
          end
        end
        BUS: begin
          // An ack in the expiring cycle still completes the beat.
          if (m_ack_i) begin
            m_cyc_o   <= 1'b0;
            m_stb_o   <= 1'b0;
            m_adr_o   <= next_adr(m_adr_o);
            remaining <= remaining - 24'd1;
            if (!m_we_o) begin
              rdat_o     <= m_dat_i;
              rdat_vld_o <= 1'b1;
              state      <= RHOLD;
            end else if (remaining > 24'd1) begin
              state      <= WDATA;
              wdat_rdy_o <= 1'b1;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end else if (to_expired) begin
            m_cyc_o  <= 1'b0;
            m_stb_o  <= 1'b0;
            status_o <= ST_TIMEOUT;
            state    <= DONE;
            done_o   <= 1'b1;
          end
        end
        RHOLD: begin
          if (rdat_rdy_i) begin
            rdat_vld_o <= 1'b0;
            if (remaining != 24'd0) begin
              state   <= BUS;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_rdy_o <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_rdy_o <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_q <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      int_q <= m_int_i;
      irq_o <= m_int_i && !int_q;
    end
  end

endmodule

// File: tb/tb_wishbone_host_master.sv
// Randomized bench: a cycle-level host/slave driver checks bus beats, data and status against
// per-command expectations derived from address, length, ack delays and the timeout budget.
module tb_wishbone_host_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_stb, cmd_rdy, cmd_we;
  logic [31:0] cmd_adr;
  logic [23:0] cmd_len;
  logic [31:0] wdat;
  logic        wdat_vld, wdat_rdy;
  logic [31:0] rdat;
  logic        rdat_vld, rdat_rdy;
  logic        done;
  logic [1:0]  status;
  logic        irq;
  logic        m_we, m_cyc, m_stb;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat_o, m_dat_i;
  logic        m_ack, m_int;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wishbone_host_master #(.TIMEOUT(TO), .TO_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_stb_i  (cmd_stb),
    .cmd_rdy_o  (cmd_rdy),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_len_i  (cmd_len),
    .wdat_i     (wdat),
    .wdat_vld_i (wdat_vld),
    .wdat_rdy_o (wdat_rdy),
    .rdat_o     (rdat),
    .rdat_vld_o (rdat_vld),
    .rdat_rdy_i (rdat_rdy),
    .done_o     (done),
    .status_o   (status),
    .irq_o      (irq),
    .m_we_o     (m_we),
    .m_cyc_o    (m_cyc),
    .m_stb_o    (m_stb),
    .m_sel_o    (m_sel),
    .m_adr_o    (m_adr),
    .m_dat_o    (m_dat_o),
    .m_dat_i    (m_dat_i),
    .m_ack_i    (m_ack),
    .m_int_i    (m_int)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] beat_adr(input logic [31:0] base, input int i);
    logic [23:0] ofs;
    ofs = base[23:0] + 24'(i);
    return {base[31:24], ofs};
  endfunction

  // One command end to end. hang_at = beat index the slave never acks (-1: all acked).
  // fdat != 0 makes data deterministic: writes fdat+i, reads fdat.
  task automatic run_cmd(input bit we, input logic [31:0] adr, input logic [23:0] len,
                         input int dmin, input int dmax, input int hang_at,
                         input logic [31:0] fdat, input int hold);
    int n, exp_beats, exp_wr, exp_rd;
    logic [1:0] exp_st;
    logic [31:0] wq[$];
    logic [31:0] rq[$];
    int beat, wi, ri, run, delay, done_cnt, rises, tail, cyc_cnt, hold_cnt;
    bit pending, exp_stb, exp_wrdy, exp_vld, exp_done, exp_crdy, first, to_seen, ack_now;

    n         = (len == 24'd0) ? 1 : int'(len);
    exp_beats = (hang_at < 0) ? n : hang_at;
    exp_st    = (hang_at < 0) ? 2'd0 : 2'd1;
    exp_wr    = we ? ((hang_at < 0) ? n : hang_at + 1) : 0;
    exp_rd    = we ? 0 : exp_beats;
    for (int i = 0; i < n; i++) wq.push_back((fdat != 0) ? fdat + 32'(i) : $urandom);
    beat = 0; wi = 0; ri = 0; run = 0; delay = 0; done_cnt = 0; rises = 0;
    pending = 0; exp_vld = 0; exp_done = 0; exp_crdy = 0; to_seen = 0;
    hold_cnt = hold;

    @(negedge clk);
    cyc_cnt = 0;
    while (!cmd_rdy && cyc_cnt < 50) begin
      @(negedge clk);
      cyc_cnt++;
    end
    chk("cmd_rdy_idle", cmd_rdy, 1);
    cmd_stb = 1; cmd_we = we; cmd_adr = adr; cmd_len = len;
    @(negedge clk);
    cmd_stb = 0; cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_len = 24'($urandom);

    exp_stb = !we; exp_wrdy = we; first = 1;
    cyc_cnt = 0; tail = -1;
    while (tail != 0 && cyc_cnt < 400) begin
      if (first) begin
        chk("cmd_rdy_busy", cmd_rdy, 0);
        chk("status_cleared", status, 0);
        first = 0;
      end
      chk("cyc_eq_stb", m_cyc, m_stb);
      chk("sel", m_sel, 4'hF);
      if (exp_stb)  chk("stb_latency", m_stb, 1);
      if (exp_wrdy) chk("wrdy_latency", wdat_rdy, 1);
      if (exp_vld)  chk("rvld_latency", rdat_vld, 1);
      if (exp_done) chk("done_latency", done, 1);
      if (exp_crdy) chk("cmd_rdy_after_done", cmd_rdy, 1);
      exp_stb = 0; exp_wrdy = 0; exp_vld = 0; exp_done = 0; exp_crdy = 0;
      chk("wrdy_while_stb", wdat_rdy & m_stb, 0);
      chk("stb_while_rvld", rdat_vld & m_stb, 0);
      if (done) begin
        done_cnt++;
        chk("status_at_done", status, exp_st);
        exp_crdy = 1;
        if (tail < 0) tail = 3;
      end

      // slave side
      ack_now = 0;
      if (m_stb) begin
        if (!pending) begin
          pending = 1; run = 0; rises++;
          delay = (beat == hang_at) ? (1 << 30) : int'($urandom_range(dmax, dmin));
        end
        run++;
        chk("beat_in_range", beat < n, 1);
        chk("adr", m_adr, beat_adr(adr, beat));
        chk("we", m_we, we);
        if (we && beat < n) chk("wdat_on_bus", m_dat_o, wq[beat]);
        if (run - 1 >= delay) begin
          ack_now = 1; pending = 0;
          beat++;
          if (!we) begin
            rq.push_back((fdat != 0) ? fdat : $urandom);
            exp_vld = 1;
          end else if (beat < n) exp_wrdy = 1;
          else exp_done = 1;
        end
      end else if (pending) begin
        pending = 0; to_seen = 1;
        chk("timeout_len", run, TO);
        chk("done_on_timeout", done, 1);
      end
      m_ack   = ack_now ? 1'b1 : (m_stb ? 1'b0 : 1'($urandom));
      m_dat_i = (ack_now && !we) ? rq[rq.size()-1] : $urandom;

      // write data source, gapped at random
      wdat_vld = (wi < n) && ($urandom_range(0, 1) == 1);
      wdat     = wdat_vld ? wq[wi] : $urandom;
      if (wdat_rdy && wdat_vld) begin
        wi++;
        exp_stb = 1;
      end

      // read data sink, optionally held off
      if (rdat_vld) begin
        if (ri < rq.size()) chk("rdat", rdat, rq[ri]);
        else chk("spurious_rvld", rdat_vld, 0);
        if (hold_cnt > 0) begin
          rdat_rdy = 0;
          hold_cnt--;
        end else rdat_rdy = 1'($urandom);
        if (rdat_rdy) begin
          ri++;
          if (ri < n) exp_stb = 1;
          else exp_done = 1;
        end
      end else rdat_rdy = 1'($urandom);

      if (tail > 0) tail--;
      @(negedge clk);
      cyc_cnt++;
    end
    if (cyc_cnt >= 400) chk("cmd_finished", 0, 1);
    chk("done_count", done_cnt, 1);
    chk("beats", beat, exp_beats);
    chk("wr_handshakes", wi, exp_wr);
    chk("rd_handshakes", ri, exp_rd);
    chk("stb_pulses", rises, exp_beats + ((hang_at < 0) ? 0 : 1));
    chk("timeout_seen", to_seen, (hang_at >= 0) ? 1 : 0);
    chk("status_held", status, exp_st);
    wdat_vld = 0; rdat_rdy = 0; m_ack = 0;
  endtask

  task automatic reset_mid_bus();
    int done_cnt, irq_cnt;
    @(negedge clk);
    cmd_stb = 1; cmd_we = 0; cmd_adr = 32'h0500_0004; cmd_len = 24'd4;
    m_ack = 0;
    @(negedge clk);
    cmd_stb = 0;
    chk("rst_pre_stb", m_stb, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_stb_drop", m_stb, 0);
    chk("rst_cyc_drop", m_cyc, 0);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    rst = 0; m_int = 1;
    done_cnt = 0; irq_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (irq) irq_cnt++;
      chk("post_rst_stb", m_stb, 0);
      chk("post_rst_cmd_rdy", cmd_rdy, 1);
    end
    chk("post_rst_done", done_cnt, 0);
    chk("irq_pulses", irq_cnt, 1);
    chk("post_rst_status", status, 0);
    chk("post_rst_rvld", rdat_vld, 0);
  endtask

  initial begin
    rst = 1; cmd_stb = 0; cmd_we = 0; cmd_adr = '0; cmd_len = '0;
    wdat = '0; wdat_vld = 0; rdat_rdy = 0; m_dat_i = '0; m_ack = 0; m_int = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_stb", m_stb, 0);
    chk("rst_cyc", m_cyc, 0);
    chk("rst_we", m_we, 0);
    chk("rst_adr", m_adr, 0);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_rdat", rdat, 0);
    chk("rst_rvld", rdat_vld, 0);
    chk("rst_wrdy", wdat_rdy, 0);
    chk("rst_done", done, 0);
    chk("rst_irq", irq, 0);
    chk("rst_status", status, 0);

    run_cmd(0, 32'h0100_0010, 24'd1, 2, 2, -1, 32'hDEADBEEF, 0);
    run_cmd(1, 32'h0200_0000, 24'd3, 0, 3, -1, 32'd1, 0);
    run_cmd(0, 32'h03FF_FFFF, 24'd2, 0, 2, -1, 32'd0, 0);
    run_cmd(0, 32'h0400_0100, 24'd1, 0, 0, 0, 32'd0, 0);
    run_cmd(0, 32'h0600_0020, 24'd0, 1, 1, -1, 32'd0, 5);
    run_cmd(0, 32'h0700_0000, 24'd2, TO - 1, TO - 1, -1, 32'd0, 0);
    run_cmd(1, 32'h08FF_FFFE, 24'd3, 0, 2, 1, 32'd0, 0);

    for (int k = 0; k < 40; k++) begin
      bit          rw;
      logic [31:0] a;
      logic [23:0] l;
      int          nn, h;
      rw = 1'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a[23:0] = 24'hFFFFFE;
      l  = 24'($urandom_range(0, 4));
      nn = (l == 24'd0) ? 1 : int'(l);
      h  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nn - 1)) : -1;
      run_cmd(rw, a, l, 0, int'($urandom_range(0, TO - 1)), h, 32'd0, int'($urandom_range(0, 3)));
    end

    reset_mid_bus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_host_master.md
Name: wishbone_host_master

Overview:
Bus master that sits directly upstream of wishbone_interconnect and drives its m_* master port. Accepts host commands (read/write, base address, beat count) and issues sequential single-beat Wishbone classic cycles. Streams write data in and read data out with valid/ready handshakes. Aborts any beat whose ack does not arrive within a timeout and reports completion status.

Parameters:
TIMEOUT, 1000, cycles m_stb_o may stay high without m_ack_i before the command aborts (range 1..2^TO_W-1)
TO_W, 16, width of the timeout counter

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
cmd_stb_i  input  1  command valid
cmd_rdy_o  output  1  command ready (high only in IDLE)
cmd_we_i  input  1  1=write, 0=read
cmd_adr_i  input  32  start address; [31:24] selects the slave, [23:0] is the slave offset
cmd_len_i  input  24  beat count; 0 is treated as 1
wdat_i  input  32  write data
wdat_vld_i  input  1  write data valid
wdat_rdy_o  output  1  write data ready
rdat_o  output  32  read data
rdat_vld_o  output  1  read data valid
rdat_rdy_i  input  1  read data ready
done_o  output  1  one-cycle pulse at command end
status_o  output  2  0=OK, 1=TIMEOUT; held until the next command is accepted
irq_o  output  1  one-cycle pulse on the rising edge of m_int_i
m_we_o, m_cyc_o, m_stb_o  output  1 each  Wishbone master controls
m_sel_o  output  4  byte select, constant 4'hF
m_adr_o  output  32  bus address
m_dat_o  output  32  bus write data
m_dat_i  input  32  bus read data
m_ack_i  input  1  bus acknowledge
m_int_i  input  1  interrupt from interconnect

Behaviour:
- All outputs are registered.
- Reset (synchronous, rst high at a clock edge):
  - state=IDLE; cyc/stb/we=0; adr/dat/rdat=0.
  - rdat_vld_o, wdat_rdy_o, done_o, irq_o = 0; status_o=0.
  - cmd_rdy_o=1 from the first cycle after reset.
  - Reset mid-cycle drops cyc/stb at that same edge; the command is discarded and no done_o pulse is produced.
- States:
  - IDLE: cmd_rdy_o=1. On cmd_stb_i, latch we, adr and remaining=(len==0 ? 1 : len); clear status_o. Write goes to WDATA; read goes to BUS with cyc/stb asserted on the next cycle.
  - WDATA: wdat_rdy_o=1. On wdat_vld_i, load m_dat_o and go to BUS, asserting cyc/stb/we on the next cycle.
  - BUS: cyc=stb=1; timeout counter increments each cycle, starting at 0 on entry.
    - m_ack_i: the next edge drops cyc/stb; offset increments and remaining decrements.
    - Read ack: capture m_dat_i into rdat_o, set rdat_vld_o, go to RHOLD.
    - Write ack: go to WDATA if remaining>0, otherwise DONE.
    - Counter reaching TIMEOUT with no ack: drop cyc/stb, status=TIMEOUT, go to DONE; remaining beats are abandoned.
    - If ack and timeout occur in the same cycle, ack wins.
  - RHOLD: rdat_o/rdat_vld_o held stable until rdat_rdy_i. On the handshake, clear vld, then go to BUS if remaining>0, otherwise DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency: a read command accepted at edge N gives stb high at N+1. If ack arrives in cycle N+1, rdat_vld_o is high at N+2 and done_o pulses the cycle after the rdat handshake.
- Bus signal rules:
  - m_ack_i is ignored while stb is low.
  - cyc and stb are always asserted and deasserted together.
  - m_adr_o changes only while stb is low.
- Address increment: +1 on [23:0] only. 24'hFFFFFF wraps to 0; [31:24] is never modified.
- Write data is never requested ahead of need: at most one outstanding beat.
- irq_o: registered rising-edge detect of m_int_i, independent of state.

Decomposition:
- Package wb_host_pkg:
  - state enum IDLE/WDATA/BUS/RHOLD/DONE
  - status codes ST_OK=2'd0, ST_TIMEOUT=2'd1
  - SLAVE_SEL_MSB=31, SLAVE_SEL_LSB=24, OFFSET_W=24
- One natural sub-module: wb_timeout_counter (clear, enable, expired output at TIMEOUT).

Test Plan:
- Single read: cmd adr=32'h0100_0010, len=1, slave acks 2 cycles after stb, m_dat_i=32'hDEADBEEF -> rdat_o=32'hDEADBEEF with vld, one stb pulse, done_o once, status=0.
- Burst write: adr=32'h0200_0000, len=3, data 1,2,3 with wdat_vld_i gapped -> three bus cycles at offsets 0,1,2 with m_dat_o=1,2,3, m_we_o=1, stb low between beats.
- Offset wrap: read adr=32'h03FF_FFFF, len=2 -> second beat at 32'h0300_0000.
- Timeout: TIMEOUT=8, no ack -> stb high for exactly 8 cycles then low, status=1, done_o pulse, no rdat_vld_o.
- Backpressure and len=0: read len=0 with rdat_rdy_i low for 5 cycles -> one beat only, rdat_o stable, no new stb until the handshake.
- Reset mid-BUS: rst high while stb high -> cyc/stb=0 at that edge, cmd_rdy_o=1 afterwards, no done_o; also m_int_i rising -> single irq_o pulse.
